// File: rtl/alu_defs_pkg.sv
// alu_defs: opcode constants and FSM state encoding shared by seq_alu and alu_comb.
package alu_defs;
   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_XOR = 3'b010;
   localparam logic [2:0] OP_NOT = 3'b011;
   localparam logic [2:0] OP_ADD = 3'b100;
   localparam logic [2:0] OP_SUB = 3'b101;
   localparam logic [2:0] OP_SHL = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;
   typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/alu_comb.sv
// alu_comb: single-cycle logic/arithmetic ops with carry (borrow for SUB) and signed overflow.
module alu_comb import alu_defs::*; #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic [WIDTH-1:0] y,
   output logic             carry,
   output logic             ovf
);
   logic [WIDTH:0] add, sub;
   assign add = {1'b0, a} + {1'b0, b};
   assign sub = {1'b0, a} - {1'b0, b};
   always_comb begin
      y = '0;
      carry = 1'b0;
      ovf = 1'b0;
      case (op)
         OP_AND: y = a & b;
         OP_OR:  y = a | b;
         OP_XOR: y = a ^ b;
         OP_NOT: y = ~a;
         OP_ADD: begin
            y = add[WIDTH-1:0];
            carry = add[WIDTH];
            ovf = (a[WIDTH-1] == b[WIDTH-1]) && (add[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            y = sub[WIDTH-1:0];
            carry = sub[WIDTH];
            ovf = (a[WIDTH-1] != b[WIDTH-1]) && (sub[WIDTH-1] != a[WIDTH-1]);
         end
         default: ;
      endcase
   end
endmodule

// File: rtl/seq_alu.sv
// seq_alu: handshaked ALU; simple ops finish in one cycle, SHL shifts one bit per cycle,
// MUL runs a WIDTH-cycle shift-add loop.
module seq_alu import alu_defs::*; #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] operand1,
   input  logic [WIDTH-1:0] operand2,
   input  logic [2:0]       alu_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero_flag,
   output logic             carry_flag,
   output logic             neg_flag,
   output logic             ovf_flag
);
   localparam int SHW = $clog2(WIDTH);
   state_t state;
   logic [2:0] op;
   logic [WIDTH-1:0] hi, lo, mcand, c_y, n_hi, n_lo, fin_y;
   logic [SHW:0] cnt;
   logic [WIDTH:0] sum;
   logic c_c, c_o, n_c, fin_c, fin_o, fin_en, accept, shl_zero;
   alu_comb #(.WIDTH(WIDTH)) u_comb (
      .a(operand1), .b(operand2), .op(alu_op), .y(c_y), .carry(c_c), .ovf(c_o)
   );
   assign in_ready = (state == IDLE) && !rst;
   assign accept = in_valid && in_ready;
   assign shl_zero = operand2[SHW-1:0] == '0;
   // MUL keeps {hi,lo} as partial product / remaining multiplier; SHL reuses lo as the shifter
   always_comb begin
      sum = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
      n_hi = (op == OP_MUL) ? sum[WIDTH:1] : hi;
      n_lo = (op == OP_MUL) ? {sum[0], lo[WIDTH-1:1]} : lo << 1;
      n_c = (op == OP_MUL) ? |sum[WIDTH:1] : lo[WIDTH-1];
      fin_y = (state == IDLE) ? ((alu_op == OP_SHL) ? operand1 : c_y) : n_lo;
      fin_c = (state == IDLE) ? c_c : n_c;
      fin_o = (state == IDLE) && c_o;
      fin_en = (state == IDLE) ? accept && alu_op != OP_MUL && !(alu_op == OP_SHL && !shl_zero)
                               : (state == EXEC) && cnt == (SHW+1)'(1);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         op <= '0;
         hi <= '0;
         lo <= '0;
         mcand <= '0;
         cnt <= '0;
         out_valid <= 1'b0;
         result <= '0;
         zero_flag <= 1'b0;
         carry_flag <= 1'b0;
         neg_flag <= 1'b0;
         ovf_flag <= 1'b0;
      end else begin
         if (fin_en) begin
            result <= fin_y;
            zero_flag <= fin_y == '0;
            neg_flag <= fin_y[WIDTH-1];
            carry_flag <= fin_c;
            ovf_flag <= fin_o;
            out_valid <= 1'b1;
            state <= DONE;
         end
         case (state)
            IDLE: if (accept) begin
               op <= alu_op;
               hi <= '0;
               lo <= (alu_op == OP_MUL) ? operand2 : operand1;
               mcand <= operand1;
               cnt <= (alu_op == OP_MUL) ? (SHW+1)'(WIDTH) : {1'b0, operand2[SHW-1:0]};
               if (!fin_en) state <= EXEC;
            end
            EXEC: begin
               hi <= n_hi;
               lo <= n_lo;
               cnt <= cnt - (SHW+1)'(1);
            end
            DONE: if (out_ready) begin
               out_valid <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed and random checks of seq_alu against a latency/arithmetic reference model.
module tb_seq_alu;
   logic clk = 0, rst = 1, in_valid = 0, out_ready = 0, chk_on = 0;
   logic in_ready, out_valid, zero_flag, carry_flag, neg_flag, ovf_flag;
   logic [7:0] operand1 = 0, operand2 = 0, result;
   logic [2:0] alu_op = 0;
   int total = 0, passed = 0;

   always #5 clk = ~clk;

   seq_alu #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .operand1(operand1), .operand2(operand2), .alu_op(alu_op),
      .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .zero_flag(zero_flag), .carry_flag(carry_flag), .neg_flag(neg_flag), .ovf_flag(ovf_flag)
   );

   task automatic chk(input string n, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", n, act, exp);
   endtask

   // arithmetic definition of each opcode: result, carry, overflow, cycles from accept to out_valid
   function automatic void ref_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] r, output logic c, output logic o, output int lat);
      logic [15:0] w;
      int s, k;
      c = 0; o = 0; lat = 1; r = 0;
      case (op)
         3'd0: r = a & b;
         3'd1: r = a | b;
         3'd2: r = a ^ b;
         3'd3: r = ~a;
         3'd4: begin
            w = {8'h0, a} + {8'h0, b}; r = w[7:0]; c = w[8];
            s = int'($signed(a)) + int'($signed(b)); o = (s > 127) || (s < -128);
         end
         3'd5: begin
            r = a - b; c = a < b;
            s = int'($signed(a)) - int'($signed(b)); o = (s > 127) || (s < -128);
         end
         3'd6: begin
            k = int'(b[2:0]); w = {8'h0, a} << k; r = w[7:0]; c = (k != 0) && w[8]; lat = k + 1;
         end
         default: begin
            w = {8'h0, a} * {8'h0, b}; r = w[7:0]; c = w[15:8] != 0; lat = 9;
         end
      endcase
   endfunction

   logic [7:0] m_res = 0, p_r;
   logic m_z = 0, m_c = 0, m_n = 0, m_o = 0, m_valid = 0, m_idle = 1, p_c, p_o, pub;
   int m_wait = 0, p_lat;

   always @(posedge clk) begin
      pub = 0;
      if (rst) begin
         m_valid = 0; m_idle = 1; m_wait = 0;
         m_res = 0; m_z = 0; m_c = 0; m_n = 0; m_o = 0;
      end else if (m_valid) begin
         if (out_ready) begin m_valid = 0; m_idle = 1; end
      end else if (m_wait > 0) begin
         m_wait--;
         pub = (m_wait == 0);
      end else if (m_idle && in_valid) begin
         ref_op(alu_op, operand1, operand2, p_r, p_c, p_o, p_lat);
         m_idle = 0;
         m_wait = p_lat - 1;
         pub = (p_lat == 1);
      end
      if (pub) begin
         m_valid = 1; m_res = p_r; m_z = (p_r == 0); m_n = p_r[7]; m_c = p_c; m_o = p_o;
      end
   end

   always @(negedge clk) if (chk_on) begin
      chk("in_ready", in_ready, m_idle && !rst);
      chk("out_valid", out_valid, m_valid);
      chk("result", result, m_res);
      chk("flags zcno", {zero_flag, carry_flag, neg_flag, ovf_flag}, {m_z, m_c, m_n, m_o});
   end

   task automatic run(input string n, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] er, input logic [3:0] ef, input int el);
      int lat = 0;
      while (!in_ready && lat < 50) begin @(posedge clk); #1; lat++; end
      chk({n, " ready"}, in_ready, 1);
      in_valid = 1; alu_op = op; operand1 = a; operand2 = b;
      @(posedge clk); #1;
      in_valid = 0; alu_op = 3'($urandom); operand1 = 8'($urandom); operand2 = 8'($urandom);
      lat = 1;
      while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
      chk({n, " latency"}, lat, el);
      chk({n, " result"}, result, er);
      chk({n, " flags zcno"}, {zero_flag, carry_flag, neg_flag, ovf_flag}, ef);
      out_ready = 1;
      @(posedge clk); #1;
      out_ready = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk_on = 1;
      chk("reset in_ready", in_ready, 0);
      chk("reset out_valid", out_valid, 0);
      chk("reset result", result, 0);
      @(negedge clk); #1;
      rst = 0;
      #1;
      chk("release in_ready", in_ready, 1);
      run("add ff+01", 3'd4, 8'hFF, 8'h01, 8'h00, 4'b1100, 1);
      run("sub 80-01", 3'd5, 8'h80, 8'h01, 8'h7F, 4'b0001, 1);
      run("sub 01-02", 3'd5, 8'h01, 8'h02, 8'hFF, 4'b0110, 1);
      run("mul 10*11", 3'd7, 8'h10, 8'h11, 8'h10, 4'b0100, 9);
      run("mul 03*05", 3'd7, 8'h03, 8'h05, 8'h0F, 4'b0000, 9);
      run("shl c1<<2", 3'd6, 8'hC1, 8'h02, 8'h04, 4'b0100, 3);
      run("shl c1<<0", 3'd6, 8'hC1, 8'h00, 8'hC1, 4'b0010, 1);
      run("not 0f", 3'd3, 8'h0F, 8'h00, 8'hF0, 4'b0010, 1);
      run("shl 01<<7", 3'd6, 8'h01, 8'h07, 8'h80, 4'b0010, 8);
      // hold DONE with out_ready low while a new request is offered
      while (!in_ready) begin @(posedge clk); #1; end
      in_valid = 1; alu_op = 3'd2; operand1 = 8'h5A; operand2 = 8'h0F;
      @(posedge clk); #1;
      alu_op = 3'd1; operand1 = 8'h01; operand2 = 8'h02;
      repeat (5) begin
         @(posedge clk); #1;
         chk("hold result", result, 8'h55);
         chk("hold out_valid", out_valid, 1);
         chk("hold in_ready", in_ready, 0);
      end
      out_ready = 1;
      @(posedge clk); #1;
      out_ready = 0;
      chk("handoff out_valid", out_valid, 0);
      chk("handoff in_ready", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 0;
      chk("post-hold result", result, 8'h03);
      chk("post-hold out_valid", out_valid, 1);
      out_ready = 1;
      @(posedge clk); #1;
      out_ready = 0;
      // reset in the 4th EXEC cycle of a MUL
      in_valid = 1; alu_op = 3'd7; operand1 = 8'h10; operand2 = 8'h11;
      @(posedge clk); #1;
      in_valid = 0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1;
      @(posedge clk); #1;
      chk("abort out_valid", out_valid, 0);
      chk("abort result", result, 0);
      chk("abort flags", {zero_flag, carry_flag, neg_flag, ovf_flag}, 0);
      chk("abort in_ready", in_ready, 0);
      rst = 0;
      #1;
      chk("abort release in_ready", in_ready, 1);
      run("and f0&3c", 3'd0, 8'hF0, 8'h3C, 8'h30, 4'b0000, 1);
      repeat (600) begin
         @(negedge clk); #1;
         in_valid = 1'($urandom_range(0, 1));
         alu_op = 3'($urandom);
         operand1 = 8'($urandom);
         operand2 = 8'($urandom);
         out_ready = $urandom_range(0, 3) != 0;
         rst = $urandom_range(0, 99) == 0;
      end
      @(negedge clk); #1;
      rst = 0; in_valid = 0; out_ready = 1;
      repeat (20) @(posedge clk);
      @(negedge clk); #1;
      chk_on = 0;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
